// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, op-codes and FSM encoding for the ALU op sequencer
package alu_pkg;

    localparam int ALU_W  = 4;
    localparam int ALU_RW = 2 * ALU_W;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_PASS = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - W-step shift-add multiplier / restoring divider datapath
module alu_iter_unit #(
    parameter int W  = 4,
    parameter int RW = 2 * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          step_i,
    input  logic          div_i,
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    output logic          last_o,
    output logic [RW-1:0] result_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic          div_q;
    logic [RW-1:0] acc_q, acc_d;
    logic [RW-1:0] mcand_q;
    logic [W-1:0]  sh_q;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_d;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    rem_sh;
    logic [W:0]    diff;

    // result_o is the value after the step taken on this edge, so the
    // sequencer can capture the final answer on the W-th step itself.
    always_comb begin
        acc_d  = acc_q + (sh_q[0] ? mcand_q : '0);
        rem_sh = {rem_q, sh_q[W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (!diff[W]) begin
            rem_d = diff[W-1:0];
            quo_d = {sh_q[W-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[W-1:0];
            quo_d = {sh_q[W-2:0], 1'b0};
        end
        result_o = div_q ? {rem_d, quo_d} : acc_d;
        last_o   = (cnt_q == CW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
            sh_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else if (start_i) begin
            div_q   <= div_i;
            acc_q   <= '0;
            mcand_q <= {{(RW-W){1'b0}}, a_i};
            sh_q    <= div_i ? a_i : b_i;
            rem_q   <= '0;
            dvs_q   <= b_i;
            cnt_q   <= '0;
        end else if (step_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (div_q) begin
                rem_q <= rem_d;
                sh_q  <= quo_d;
            end else begin
                acc_q   <= acc_d;
                mcand_q <= mcand_q << 1;
                sh_q    <= sh_q >> 1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command/response sequencer for the 4-bit ALU
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int W  = ALU_W,
    parameter int RW = 2 * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [W-1:0]  cmd_a,
    input  logic [W-1:0]  cmd_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [RW-1:0] rsp_result,
    output logic          rsp_err,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [2:0]    op_q;
    logic [W-1:0]  a_q, b_q;
    logic [RW-1:0] result_q, result_d;
    logic          err_q, err_d;
    logic [RW-1:0] single_res;
    logic          accept, div_zero, iterative;
    logic          iter_last;
    logic [RW-1:0] iter_result;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign accept     = cmd_valid && cmd_ready;
    assign div_zero   = (op_q == OP_DIV) && (b_q == '0);
    assign iterative  = (op_q == OP_MUL) || ((op_q == OP_DIV) && !div_zero);

    alu_iter_unit #(.W(W), .RW(RW)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept),
        .step_i   ((state_q == ST_EXEC) && iterative),
        .div_i    (cmd_op == OP_DIV),
        .a_i      (cmd_a),
        .b_i      (cmd_b),
        .last_o   (iter_last),
        .result_o (iter_result)
    );

    always_comb begin
        single_res = '0;
        case (op_q)
            OP_ADD:  single_res = {{(RW-W){1'b0}}, a_q} + {{(RW-W){1'b0}}, b_q};
            OP_SUB:  single_res = {{(RW-W){1'b0}}, a_q} - {{(RW-W){1'b0}}, b_q};
            OP_AND:  single_res = {{(RW-W){1'b0}}, a_q & b_q};
            OP_DIV:  single_res = '1;
            OP_MUL:  single_res = '0;
            default: single_res = {b_q, a_q};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: begin
                if (!iterative || iter_last) begin
                    result_d = iterative ? iter_result : single_res;
                    err_d    = div_zero;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            err_q    <= err_d;
            if (accept) begin
                op_q <= cmd_op;
                a_q  <= cmd_a;
                b_q  <= cmd_b;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - vector table plus scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic       rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0] rsp_result;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic       err;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       err;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_result", {24'd0, rsp_result}, {24'd0, e.res});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Present a command, wait for acceptance, optionally record its expectation.
    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] res, input logic err, input bit push);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'd0, n < 50}, 32'd1);
        @(posedge clk);
        if (push) sbq.push_back(exp_t'{res, err});
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_a     = 4'($urandom);
        cmd_b     = 4'($urandom);
    endtask

    task automatic wait_lat(input int lat);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, lat);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rsp_drop_timeout", {31'd0, n < 50}, 32'd1);
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{OP_ADD,  4'd9,  4'd7,  8'h10, 1'b0, 1};
        vecs[1]  = '{OP_SUB,  4'd3,  4'd5,  8'hFE, 1'b0, 1};
        vecs[2]  = '{OP_MUL,  4'd15, 4'd15, 8'hE1, 1'b0, 4};
        vecs[3]  = '{OP_DIV,  4'd13, 4'd3,  8'h14, 1'b0, 4};
        vecs[4]  = '{OP_DIV,  4'd9,  4'd0,  8'hFF, 1'b1, 1};
        vecs[5]  = '{OP_AND,  4'd12, 4'd10, 8'h08, 1'b0, 1};
        vecs[6]  = '{3'd7,    4'd1,  4'd2,  8'h21, 1'b0, 1};
        vecs[7]  = '{OP_MUL,  4'd0,  4'd9,  8'h00, 1'b0, 4};
        vecs[8]  = '{OP_DIV,  4'd15, 4'd1,  8'h0F, 1'b0, 4};
        vecs[9]  = '{OP_DIV,  4'd7,  4'd9,  8'h70, 1'b0, 4};
        vecs[10] = '{OP_ADD,  4'd15, 4'd15, 8'h1E, 1'b0, 1};
        vecs[11] = '{OP_SUB,  4'd0,  4'd15, 8'hF1, 1'b0, 1};
        vecs[12] = '{OP_DIV,  4'd15, 4'd15, 8'h01, 1'b0, 4};
        vecs[13] = '{3'd6,    4'd10, 4'd5,  8'h5A, 1'b0, 1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_result", {24'd0, rsp_result}, 32'd0);
        chk("reset_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err, 1'b1);
            chk("exec_busy", {31'd0, busy}, 32'd1);
            wait_lat(vecs[i].lat);
            wait_idle();
        end

        // Backpressure: result held, no second command accepted.
        rsp_ready = 1'b0;
        issue(OP_MUL, 4'd6, 4'd7, 8'h2A, 1'b0, 1'b1);
        wait_lat(4);
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_ADD;
            cmd_a     = 4'd1;
            cmd_b     = 4'd1;
            @(posedge clk);
            #1;
            chk("bp_result", {24'd0, rsp_result}, 32'h2A);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_extra", {31'd0, rsp_valid}, 32'd0);

        // Reset two cycles into a DIV aborts it without a response.
        issue(OP_DIV, 4'd13, 4'd3, 8'h14, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_no_stale", {31'd0, rsp_valid}, 32'd0);

        // Back-to-back commands with cmd_valid held high.
        begin
            logic [2:0] ops[3];
            logic [3:0] as[3];
            logic [3:0] bs[3];
            logic [7:0] rs[3];
            int         n;
            ops = '{OP_AND, OP_PASS, OP_ADD};
            as  = '{4'd12, 4'd1, 4'd15};
            bs  = '{4'd10, 4'd2, 4'd15};
            rs  = '{8'h08, 8'h21, 8'h1E};
            @(negedge clk);
            cmd_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                cmd_op = ops[i];
                cmd_a  = as[i];
                cmd_b  = bs[i];
                n = 0;
                while (!cmd_ready && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("b2b_accept", {31'd0, n < 50}, 32'd1);
                @(posedge clk);
                sbq.push_back(exp_t'{rs[i], 1'b0});
                #1;
            end
            cmd_valid = 1'b0;
            n = 0;
            while ((sbq.size() != 0 || rsp_valid) && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("b2b_drained", sbq.size(), 0);
            repeat (4) @(posedge clk);
            #1;
            chk("b2b_no_dup", {31'd0, rsp_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
